// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a sequential PC generator that feeds a circular buffer
// of {pc, instr} entries. Decode pops the head entry, and a redirect flushes the buffer.
module instr_fetch_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] INSTR_LENGTH = 32'd4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_instr_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;
    logic          empty, full, pop, push;

    assign empty   = (count == '0);
    assign full    = (count == FULL);
    assign valid_o = ~empty & ~redirect_i;
    assign pop     = valid_o & ready_i;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign push    = start_i & ~redirect_i & (~full | pop);

    assign imem_addr_o = fetch_pc;
    assign count_o     = count;
    assign instr_o     = empty ? NOP   : mem[rd_ptr].instr;
    assign pc_o        = empty ? '0    : mem[rd_ptr].pc;

    // Storage is not reset; the outputs are gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i)
            mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + INSTR_LENGTH;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue. A queue-based reference model is checked every cycle,
// and directed scenarios add hand-computed literal checks.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, start, redirect, ready;
    logic [31:0] redirect_pc, imem_addr, imem_instr, instr, pc;
    logic        valid;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // The instruction memory returns the address plus 0x100.
    assign imem_instr = imem_addr + 32'h100;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .INSTR_LENGTH(32'd4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .imem_addr_o(imem_addr),
        .imem_instr_i(imem_instr), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_o(instr), .pc_o(pc), .valid_o(valid), .ready_i(ready), .count_o(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of queued {pc, instr} pairs and the next fetch address.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        q[$];
    logic [31:0] mpc;
    bit          model_ok = 0;

    always @(negedge clk) begin
        bit m_valid, m_pop, m_push;
        m_valid = (q.size() != 0) && !redirect;
        if (model_ok) begin
            chk("m_addr",  imem_addr, mpc);
            chk("m_count", {29'b0, count}, q.size());
            chk("m_valid", {31'b0, valid}, {31'b0, m_valid});
            chk("m_instr", instr, q.size() != 0 ? q[0].instr : 32'h13);
            chk("m_pc",    pc,    q.size() != 0 ? q[0].pc    : 32'h0);
        end
        if (rst) begin
            q.delete();
            mpc = 32'h0;
            model_ok = 1;
        end else if (redirect) begin
            q.delete();
            mpc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            m_pop  = m_valid && ready;
            m_push = start && (q.size() < DEPTH || m_pop);
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back('{pc: mpc, instr: mpc + 32'h100});
                mpc = mpc + 32'd4;
            end
        end
    end

    task automatic set(input logic r, input logic s, input logic rd,
                       input logic rdr, input logic [31:0] rpc);
        rst = r; start = s; ready = rd; redirect = rdr; redirect_pc = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();

        // Reset state
        set(0, 0, 0, 0, 0);
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_pc",    pc, 0);
        chk("rst_addr",  imem_addr, 0);

        // Streaming: one instruction per cycle
        set(0, 1, 1, 0, 0);
        chk("s_valid0", {31'b0, valid}, 0);
        tick();
        chk("s_valid1", {31'b0, valid}, 1);
        chk("s_pc0", pc, 32'h0);   chk("s_in0", instr, 32'h100);
        tick();
        chk("s_pc1", pc, 32'h4);   chk("s_in1", instr, 32'h104);
        tick();
        chk("s_pc2", pc, 32'h8);   chk("s_in2", instr, 32'h108);
        set(1, 0, 0, 0, 0); tick();

        // Backpressure until full, then a simultaneous pop and push
        set(0, 1, 0, 0, 0);
        repeat (6) tick();
        chk("f_count", {29'b0, count}, 4);
        chk("f_addr",  imem_addr, 32'h10);
        chk("f_pc",    pc, 32'h0);
        chk("f_instr", instr, 32'h100);
        set(0, 1, 1, 0, 0);
        tick();
        chk("pp_count", {29'b0, count}, 4);
        chk("pp_pc",    pc, 32'h4);
        chk("pp_addr",  imem_addr, 32'h14);

        // Drain to 3 entries, then redirect to a misaligned target
        set(0, 0, 1, 0, 0); tick();
        chk("r_count3", {29'b0, count}, 3);
        set(0, 1, 1, 1, 32'h203);
        chk("r_valid", {31'b0, valid}, 0);
        tick();
        set(0, 1, 0, 0, 0);
        chk("r_count", {29'b0, count}, 0);
        chk("r_addr",  imem_addr, 32'h200);
        tick();
        chk("r_pc",    pc, 32'h200);
        chk("r_instr", instr, 32'h300);

        // Fetch address wrap-around
        set(0, 1, 0, 1, 32'hFFFF_FFFC); tick();
        set(0, 1, 0, 0, 0);
        chk("w_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("w_addr1", imem_addr, 32'h0);
        chk("w_pc0",   pc, 32'hFFFF_FFFC);
        chk("w_in0",   instr, 32'h0000_00FC);
        tick();
        chk("w_count", {29'b0, count}, 2);

        // Drain with fetch disabled
        set(0, 0, 1, 0, 0);
        chk("d_pc0", pc, 32'hFFFF_FFFC);
        tick();
        chk("d_pc1", pc, 32'h0);
        tick();
        chk("d_valid", {31'b0, valid}, 0);
        chk("d_instr", instr, 32'h13);
        chk("d_addr",  imem_addr, 32'h4);

        // Reset overrides redirect while full
        set(0, 1, 0, 0, 0);
        repeat (5) tick();
        chk("x_full", {29'b0, count}, 4);
        set(1, 1, 1, 1, 32'h500); tick();
        set(0, 0, 0, 0, 0);
        chk("x_count", {29'b0, count}, 0);
        chk("x_addr",  imem_addr, 32'h0);
        chk("x_valid", {31'b0, valid}, 0);

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 48; i++) begin
            set(0, (i % 5) != 0, (i % 3) != 1, i == 20 || i == 37,
                32'h1000 + 32'(i * 8) + 32'd1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
